// File: rtl/ccg_vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ccg_seq_pkg
//  Purpose  : Shared types and helpers for the CCG exhaustive vector
//             sequencer. Holds the sequencer state encoding, the default
//             MISR polynomial and seed, and one MISR step function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ccg_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CAPTURE = 2'd2,
      S_FINISH  = 2'd3
   } seq_state_t;

   // Widest signature the step function handles. Callers pass narrower
   // values zero-extended and give the real width in 'width'.
   localparam int unsigned c_max_sig_w = 64;
   localparam int unsigned c_idx_w     = $clog2(c_max_sig_w);

   localparam logic [15:0] c_def_poly = 16'h1021;
   localparam logic [15:0] c_def_seed = 16'hFFFF;

   // One MISR step: shift left, fold POLY back in when the bit shifted out
   // was set, then XOR in the new data word. Result is masked to 'width'.
   function automatic logic [c_max_sig_w-1:0] misr_step(
      input logic [c_max_sig_w-1:0] sig,
      input logic [c_max_sig_w-1:0] poly,
      input logic [c_max_sig_w-1:0] data,
      input int unsigned            width
   );
      logic [c_max_sig_w-1:0] fb;
      logic [c_max_sig_w-1:0] mask;
      logic [c_idx_w-1:0]     msb_idx;
      msb_idx = c_idx_w'(width - 1);
      fb      = sig[msb_idx] ? poly : '0;
      mask    = (width >= c_max_sig_w) ? '1
              : ((c_max_sig_w'(1) << width) - c_max_sig_w'(1));
      return ((sig << 1) ^ fb ^ data) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ccg_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ccg_vector_sequencer_if
//  Purpose  : Bundles the harness-side control/status signals and the
//             circuit-side stimulus/response bus of the vector sequencer.
//  Ports    : start, abort, golden_sig  (harness -> sequencer)
//             busy, done, pass, signature (sequencer -> harness)
//             x (sequencer -> circuit), f (circuit -> sequencer)
//             modport slave  : the sequencer
//             modport master : harness plus circuit side
//  Revision : 1.0  initial release
// ============================================================================
interface ccg_vector_sequencer_if #(
   parameter int unsigned N_IN  = 2,
   parameter int unsigned N_OUT = 5,
   parameter int unsigned SIG_W = 16
);
   logic             start;
   logic             abort;
   logic [SIG_W-1:0] golden_sig;
   logic [N_IN-1:0]  x;
   logic [N_OUT-1:0] f;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;

   modport master (
      output start, abort, golden_sig, f,
      input  x, busy, done, pass, signature
   );

   modport slave (
      input  start, abort, golden_sig, f,
      output x, busy, done, pass, signature
   );
endinterface
`default_nettype wire

// File: rtl/ccg_vector_sequencer_misr.sv
`default_nettype none
// ============================================================================
//  Module   : ccg_misr
//  Purpose  : Multiple-input signature register compacting the circuit
//             outputs, one word per shift_en cycle.
//  Ports    : clk, rst_n   clock, synchronous active-low reset
//             load_seed    reload SEED (wins over shift_en)
//             shift_en     absorb data_in this edge
//             data_in      circuit output word, zero-extended to SIG_W
//             sig          current signature
//  Revision : 1.0  initial release
// ============================================================================
module ccg_misr
   import ccg_seq_pkg::*;
#(
   parameter int unsigned      SIG_W = 16,
   parameter int unsigned      N_OUT = 5,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(c_def_poly),
   parameter logic [SIG_W-1:0] SEED  = SIG_W'(c_def_seed)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_seed,
   input  logic             shift_en,
   input  logic [N_OUT-1:0] data_in,
   output logic [SIG_W-1:0] sig
);

   logic [SIG_W-1:0]       r_sig;
   logic [c_max_sig_w-1:0] w_step;

   always_comb begin
      w_step = misr_step(c_max_sig_w'(r_sig), c_max_sig_w'(POLY),
                         c_max_sig_w'(data_in), SIG_W);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sig <= SEED;
      end else if (load_seed) begin
         r_sig <= SEED;
      end else if (shift_en) begin
         r_sig <= w_step[SIG_W-1:0];
      end
   end

   assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/ccg_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ccg_vector_sequencer
//  Purpose  : Drives every input vector 0..2^N_IN-1 onto a combinational
//             benchmark circuit, holds each for SETTLE_CYC cycles, compacts
//             the outputs into a MISR and compares against a golden value.
//  Ports    : clk        rising-edge clock
//             rst_n      synchronous active-low reset
//             bus.slave  start/abort/golden_sig in, busy/done/pass/signature
//                        out, x to circuit, f from circuit
//  Revision : 1.0  initial release
// ============================================================================
module ccg_vector_sequencer
   import ccg_seq_pkg::*;
#(
   parameter int unsigned      N_IN       = 2,
   parameter int unsigned      N_OUT      = 5,
   parameter int unsigned      SETTLE_CYC = 1,
   parameter int unsigned      SIG_W      = 16,
   parameter logic [SIG_W-1:0] POLY       = SIG_W'(c_def_poly),
   parameter logic [SIG_W-1:0] SEED       = SIG_W'(c_def_seed)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ccg_vector_sequencer_if.slave  bus
);

   localparam int unsigned      c_cnt_w      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(SETTLE_CYC - 1);
   localparam int unsigned      c_vec_w      = N_IN + 1;
   // One extra bit keeps the last vector reachable by compare without wrap.
   localparam logic [c_vec_w-1:0] c_last_vec  = c_vec_w'((2 ** N_IN) - 1);

   seq_state_t         r_state;
   seq_state_t         w_state_nxt;
   logic [c_cnt_w-1:0] r_settle_cnt;
   logic [c_vec_w-1:0] r_vec;
   logic [N_IN-1:0]    r_x;
   logic               r_pass;
   logic [SIG_W-1:0]   w_sig;
   logic               w_start_run;
   logic               w_abort_run;
   logic               w_capture;
   logic               w_finish;
   logic               w_last_vec;

   assign w_last_vec = (r_vec == c_last_vec);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // abort outranks every in-run action, including the CAPTURE shift.
   always_comb begin
      w_state_nxt = r_state;
      w_start_run = 1'b0;
      w_abort_run = 1'b0;
      w_capture   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_start_run = 1'b1;
               w_state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (bus.abort) begin
               w_abort_run = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_settle_cnt == '0) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (bus.abort) begin
               w_abort_run = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_capture   = 1'b1;
               w_state_nxt = w_last_vec ? S_FINISH : S_SETTLE;
            end
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
            if (bus.abort) begin
               w_abort_run = 1'b1;
            end else begin
               w_finish = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_settle_cnt <= '0;
         r_vec        <= '0;
         r_x          <= '0;
         r_pass       <= 1'b0;
      end else if (w_start_run) begin
         r_settle_cnt <= c_cnt_reload;
         r_vec        <= '0;
         r_x          <= '0;
         r_pass       <= 1'b0;
      end else if (w_abort_run) begin
         r_vec        <= '0;
         r_x          <= '0;
         r_pass       <= 1'b0;
      end else if (r_state == S_SETTLE) begin
         if (r_settle_cnt != '0) begin
            r_settle_cnt <= r_settle_cnt - c_cnt_w'(1);
         end
      end else if (w_capture && !w_last_vec) begin
         r_vec        <= r_vec + c_vec_w'(1);
         r_x          <= N_IN'(r_vec + c_vec_w'(1));
         r_settle_cnt <= c_cnt_reload;
      end else if (w_finish) begin
         r_pass <= (w_sig == bus.golden_sig);
      end
   end

   ccg_misr #(
      .SIG_W (SIG_W),
      .N_OUT (N_OUT),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_seed (w_start_run),
      .shift_en  (w_capture),
      .data_in   (bus.f),
      .sig       (w_sig)
   );

   assign bus.x         = r_x;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = w_finish;
   assign bus.pass      = r_pass;
   assign bus.signature = w_sig;

endmodule
`default_nettype wire

// File: tb/tb_ccg_vector_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccg_vector_sequencer
//  Purpose  : Self-checking bench for ccg_vector_sequencer. Two instances
//             (SETTLE_CYC=1 and 3) each drive a model of the CCGRCG6-class
//             netlist; expected signatures are queued at start and popped
//             at every capture.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_ccg_vector_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   ccg_vector_sequencer_if #(.N_IN(2), .N_OUT(5), .SIG_W(16)) if_a ();
   ccg_vector_sequencer_if #(.N_IN(2), .N_OUT(5), .SIG_W(16)) if_b ();

   ccg_vector_sequencer #(.N_IN(2), .N_OUT(5), .SETTLE_CYC(1), .SIG_W(16)) dut_a (
      .clk (clk), .rst_n (rst_n), .bus (if_a.slave)
   );
   ccg_vector_sequencer #(.N_IN(2), .N_OUT(5), .SETTLE_CYC(3), .SIG_W(16)) dut_b (
      .clk (clk), .rst_n (rst_n), .bus (if_b.slave)
   );

   // Netlist model: f={f5..f1} for x=0..3
   function automatic logic [4:0] netlist(input logic [1:0] xv);
      case (xv)
         2'd0:    return 5'h00;
         2'd1:    return 5'h0A;
         2'd2:    return 5'h15;
         default: return 5'h1D;
      endcase
   endfunction

   always_comb if_a.f = netlist(if_a.x);
   always_comb if_b.f = netlist(if_b.x);

   // Currently observed instance
   int          sel;
   logic [1:0]  m_x;
   logic        m_busy, m_done, m_pass;
   logic [15:0] m_sig;
   always_comb begin
      m_x    = (sel != 0) ? if_b.x         : if_a.x;
      m_busy = (sel != 0) ? if_b.busy      : if_a.busy;
      m_done = (sel != 0) ? if_b.done      : if_a.done;
      m_pass = (sel != 0) ? if_b.pass      : if_a.pass;
      m_sig  = (sel != 0) ? if_b.signature : if_a.signature;
   end

   int total = 0;
   int bad   = 0;
   logic [15:0] sb[$];
   logic [15:0] trace[4];

   typedef struct {
      logic [15:0] golden;
      int          which;
      bit          exp_pass;
      int          restart_at;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_start(input int s, input logic v);
      if (s != 0) if_b.start = v;
      else        if_a.start = v;
   endtask

   // Starts a run (start high from now to the next edge) and checks every
   // cycle through the first idle cycle after done. Returns at the negedge
   // of that idle cycle so a following call starts back-to-back.
   task automatic run(input logic [15:0] golden, input int s, input bit exp_pass,
                      input int restart_at);
      int          settle;
      int          n;
      int          xe;
      logic [15:0] exp_s;
      settle          = (s != 0) ? 3 : 1;
      n               = 4 * (settle + 1);
      sel             = s;
      if_a.golden_sig = golden;
      if_b.golden_sig = golden;
      for (int v = 0; v < 4; v++) sb.push_back(trace[v]);
      drive_start(s, 1'b1);
      @(posedge clk);
      #1 drive_start(s, 1'b0);
      for (int k = 0; k <= n + 1; k++) begin
         @(negedge clk);
         if (k <= n) begin
            xe = k / (settle + 1);
            if (xe > 3) xe = 3;
            check($sformatf("x s%0d k%0d", s, k), 32'(m_x), 32'(xe));
            check($sformatf("busy s%0d k%0d", s, k), 32'(m_busy), 32'd1);
            check($sformatf("done s%0d k%0d", s, k), 32'(m_done), (k == n) ? 32'd1 : 32'd0);
            if (k > 0 && (k % (settle + 1)) == 0) begin
               if (sb.size() == 0) begin
                  check("scoreboard empty", 32'd1, 32'd0);
               end else begin
                  exp_s = sb.pop_front();
                  check($sformatf("sig s%0d k%0d", s, k), 32'(m_sig), 32'(exp_s));
               end
            end
         end else begin
            check($sformatf("idle busy s%0d", s), 32'(m_busy), 32'd0);
            check($sformatf("idle done s%0d", s), 32'(m_done), 32'd0);
            check($sformatf("pass s%0d g%h", s, golden), 32'(m_pass), 32'(exp_pass));
            check($sformatf("final sig s%0d", s), 32'(m_sig), 32'h0E00);
         end
         if (k < n + 1) begin
            @(posedge clk);
            #1 drive_start(s, (k + 1 == restart_at) ? 1'b1 : 1'b0);
         end
      end
   endtask

   initial begin
      trace[0] = 16'hEFDF;
      trace[1] = 16'hCF95;
      trace[2] = 16'h8F1E;
      trace[3] = 16'h0E00;
      tbl[0] = '{16'h0E00, 0, 1'b1, -1};
      tbl[1] = '{16'h0E01, 0, 1'b0, -1};
      tbl[2] = '{16'h0E00, 0, 1'b1,  3};   // start re-pulsed while busy
      tbl[3] = '{16'h0E00, 0, 1'b1, -1};   // back-to-back after done
      tbl[4] = '{16'h0E00, 1, 1'b1, -1};   // SETTLE_CYC=3 instance
      tbl[5] = '{16'h8E00, 0, 1'b0, -1};

      sel = 0;
      rst_n = 1'b0;
      if_a.start = 1'b0; if_a.abort = 1'b0; if_a.golden_sig = '0;
      if_b.start = 1'b0; if_b.abort = 1'b0; if_b.golden_sig = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst x",    32'(if_a.x),         32'd0);
      check("rst sig",  32'(if_a.signature), 32'hFFFF);
      check("rst busy", 32'(if_a.busy),      32'd0);
      check("rst done", 32'(if_a.done),      32'd0);
      check("rst pass", 32'(if_a.pass),      32'd0);
      check("rst sig b", 32'(if_b.signature), 32'hFFFF);

      for (int i = 0; i < 6; i++)
         run(tbl[i].golden, tbl[i].which, tbl[i].exp_pass, tbl[i].restart_at);

      // Abort during the SETTLE of vector 1
      sel = 0;
      if_a.start = 1'b1;
      @(posedge clk); #1 if_a.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort pre x", 32'(if_a.x), 32'd1);
      if_a.abort = 1'b1;
      @(posedge clk); #1 if_a.abort = 1'b0;
      check("abort busy", 32'(if_a.busy),      32'd0);
      check("abort done", 32'(if_a.done),      32'd0);
      check("abort pass", 32'(if_a.pass),      32'd0);
      check("abort sig",  32'(if_a.signature), 32'hEFDF);
      check("abort x",    32'(if_a.x),         32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("abort quiet done %0d", k), 32'(if_a.done), 32'd0);
         check($sformatf("abort quiet busy %0d", k), 32'(if_a.busy), 32'd0);
      end

      // start and abort together in IDLE: start wins, then abort exits
      if_a.start = 1'b1; if_a.abort = 1'b1;
      @(posedge clk); #1 if_a.start = 1'b0; if_a.abort = 1'b0;
      check("start wins busy", 32'(if_a.busy),      32'd1);
      check("start wins sig",  32'(if_a.signature), 32'hFFFF);
      if_a.abort = 1'b1;
      @(posedge clk); #1 if_a.abort = 1'b0;
      check("abort exit busy", 32'(if_a.busy), 32'd0);

      // Reset pulse during vector 2
      if_a.start = 1'b1;
      @(posedge clk); #1 if_a.start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("pre-rst x", 32'(if_a.x), 32'd2);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      check("midrst x",    32'(if_a.x),         32'd0);
      check("midrst sig",  32'(if_a.signature), 32'hFFFF);
      check("midrst busy", 32'(if_a.busy),      32'd0);
      check("midrst done", 32'(if_a.done),      32'd0);
      check("midrst pass", 32'(if_a.pass),      32'd0);
      run(16'h0E00, 0, 1'b1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
